// File: rtl/risc16_top.sv
// Single-cycle 16-bit RISC core: PC, hardwired program ROM, 8x16 register file, ALU and data memory.
// Every instruction commits on one rising edge; `result` exposes internal state selected by `test`.
module risc16_top #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  test,
  output logic [15:0] result
);

  localparam int unsigned ImemAw = $clog2(IMEM_DEPTH);
  localparam int unsigned DmemAw = $clog2(DMEM_DEPTH);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpAddi = 4'h4;
  localparam logic [3:0] OpLw   = 4'h5;
  localparam logic [3:0] OpSw   = 4'h6;
  localparam logic [3:0] OpBeq  = 4'h7;
  localparam logic [3:0] OpJ    = 4'h8;

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr;
  logic [15:0] rf_q [8];
  // No reset on data memory: contents survive a core reset.
  logic [15:0] dmem_q [DMEM_DEPTH] = '{default: 16'h0000};

  logic [3:0]        op;
  logic [2:0]        ra, rb, rc;
  logic [15:0]       imm6_sext;
  logic [15:0]       ra_val, rb_val, rc_val;
  logic [15:0]       ea;
  logic [DmemAw-1:0] dm_addr;
  logic [15:0]       alu;
  logic              rf_we, dm_we;

  always_comb begin
    case (pc_q[ImemAw-1:0])
      ImemAw'(0): instr = 16'h4205;
      ImemAw'(1): instr = 16'h4403;
      ImemAw'(2): instr = 16'h0650;
      ImemAw'(3): instr = 16'h1850;
      ImemAw'(4): instr = 16'h6600;
      ImemAw'(5): instr = 16'h5A00;
      ImemAw'(6): instr = 16'h7AC1;
      ImemAw'(7): instr = 16'h4C01;
      ImemAw'(8): instr = 16'h8008;
      default:    instr = 16'h0000;
    endcase
  end

  assign op        = instr[15:12];
  assign ra        = instr[11:9];
  assign rb        = instr[8:6];
  assign rc        = instr[5:3];
  assign imm6_sext = {{10{instr[5]}}, instr[5:0]};

  assign ra_val  = (ra == 3'd0) ? 16'h0000 : rf_q[ra];
  assign rb_val  = (rb == 3'd0) ? 16'h0000 : rf_q[rb];
  assign rc_val  = (rc == 3'd0) ? 16'h0000 : rf_q[rc];
  assign ea      = rb_val + imm6_sext;
  assign dm_addr = ea[DmemAw-1:0];

  always_comb begin
    alu   = 16'h0000;
    rf_we = 1'b0;
    dm_we = 1'b0;
    pc_d  = pc_q + 16'd1;
    case (op)
      OpAdd:  begin alu = rb_val + rc_val; rf_we = 1'b1; end
      OpSub:  begin alu = rb_val - rc_val; rf_we = 1'b1; end
      OpAnd:  begin alu = rb_val & rc_val; rf_we = 1'b1; end
      OpOr:   begin alu = rb_val | rc_val; rf_we = 1'b1; end
      OpAddi: begin alu = ea;              rf_we = 1'b1; end
      OpLw:   begin alu = dmem_q[dm_addr]; rf_we = 1'b1; end
      OpSw:   begin alu = ea;              dm_we = 1'b1; end
      OpBeq: begin
        alu = ra_val - rb_val;
        if (alu == 16'h0000) pc_d = pc_q + 16'd1 + imm6_sext;
      end
      OpJ:     pc_d = {4'h0, instr[11:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else if (rf_we && ra != 3'd0) begin
      rf_q[ra] <= alu;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && dm_we) dmem_q[dm_addr] <= ra_val;
  end

  always_comb begin
    case (test)
      2'b00:   result = alu;
      2'b01:   result = pc_q;
      2'b10:   result = instr;
      default: result = dmem_q[0];
    endcase
  end

endmodule

// File: tb/tb_risc16_top.sv
// Bench for risc16_top: directed program walk-through, then random reset/test selection
// compared against an instruction-level model of the processor.
module tb_risc16_top;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  test;
  logic [15:0] result;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  risc16_top dut (
    .clk    (clk),
    .reset  (reset),
    .test   (test),
    .result (result)
  );

  always #5 clk = ~clk;

  // Architectural model state
  logic [15:0] m_pc;
  logic [15:0] m_r [8];
  logic [15:0] m_mem [256];

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a[7:0])
      8'd0: return 16'h4205;
      8'd1: return 16'h4403;
      8'd2: return 16'h0650;
      8'd3: return 16'h1850;
      8'd4: return 16'h6600;
      8'd5: return 16'h5A00;
      8'd6: return 16'h7AC1;
      8'd7: return 16'h4C01;
      8'd8: return 16'h8008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] sext6(input logic [15:0] w);
    return {{10{w[5]}}, w[5:0]};
  endfunction

  function automatic logic [15:0] model_alu();
    logic [15:0] w, a, b, c, addr;
    w = rom(m_pc);
    a = m_r[w[11:9]];
    b = m_r[w[8:6]];
    c = m_r[w[5:3]];
    addr = b + sext6(w);
    case (w[15:12])
      4'd0: return b + c;
      4'd1: return b - c;
      4'd2: return b & c;
      4'd3: return b | c;
      4'd4: return addr;
      4'd5: return m_mem[addr[7:0]];
      4'd6: return addr;
      4'd7: return a - b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] model_result(input logic [1:0] t);
    case (t)
      2'd0: return model_alu();
      2'd1: return m_pc;
      2'd2: return rom(m_pc);
      default: return m_mem[0];
    endcase
  endfunction

  task automatic model_step(input logic rst);
    logic [15:0] w, a, b, v, addr;
    if (rst) begin
      m_pc = 16'h0000;
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
      return;
    end
    w = rom(m_pc);
    a = m_r[w[11:9]];
    b = m_r[w[8:6]];
    v = model_alu();
    addr = b + sext6(w);
    m_pc = m_pc + 16'd1;
    if (w[15:12] <= 4'd5) begin
      if (w[11:9] != 3'd0) m_r[w[11:9]] = v;
    end else if (w[15:12] == 4'd6) begin
      m_mem[addr[7:0]] = a;
    end else if (w[15:12] == 4'd7) begin
      if (a == b) m_pc = m_pc + sext6(w);
    end else if (w[15:12] == 4'd8) begin
      m_pc = {4'h0, w[11:0]};
    end
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    vectors++;
    assert (result === exp)
    else begin
      miscompares++;
      $error("FAIL %s: result=%h expected=%h", tag, result, exp);
    end
  endtask

  // Drive one cycle: set inputs mid-low-phase, compare before the edge, advance the model.
  task automatic tick(input logic rst, input logic [1:0] tst, input string tag,
                      input logic [15:0] exp);
    @(negedge clk);
    reset = rst;
    test  = tst;
    #1;
    check(tag, exp);
    if (exp !== model_result(tst)) begin
      check({tag, "_model"}, model_result(tst));
    end
    @(posedge clk);
    model_step(rst);
  endtask

  initial begin
    logic [15:0] pc_seq [9];
    logic        r;
    logic [1:0]  t;

    m_pc = 16'h0000;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;

    reset = 1'b1;
    test  = 2'b01;
    @(posedge clk);
    model_step(1'b1);

    // Reset held: result shows the instruction at PC 0
    tick(1'b1, 2'b01, "rst_pc", 16'h0000);
    tick(1'b1, 2'b10, "rst_instr", 16'h4205);
    tick(1'b1, 2'b00, "rst_alu", 16'h0005);
    tick(1'b1, 2'b11, "rst_dmem0", 16'h0000);

    // First run, ALU observation and DMEM[0] across the store
    tick(1'b0, 2'b00, "alu_addi5", 16'h0005);
    tick(1'b0, 2'b00, "alu_addi3", 16'h0003);
    tick(1'b0, 2'b00, "alu_add", 16'h0008);
    tick(1'b0, 2'b00, "alu_sub", 16'h0002);
    tick(1'b0, 2'b11, "dmem0_pre_sw", 16'h0000);
    tick(1'b0, 2'b00, "alu_lw", 16'h0008);
    tick(1'b0, 2'b11, "dmem0_post_sw", 16'h0008);
    tick(1'b0, 2'b01, "pc_halt", 16'h0008);
    tick(1'b0, 2'b00, "alu_j", 16'h0000);
    tick(1'b0, 2'b01, "pc_halt2", 16'h0008);

    // Reset out of the halt loop; memory survives, program re-runs identically
    tick(1'b1, 2'b11, "dmem0_in_rst", 16'h0008);
    pc_seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd8, 16'd8};
    foreach (pc_seq[i]) tick(1'b0, 2'b01, $sformatf("pc_seq%0d", i), pc_seq[i]);
    tick(1'b0, 2'b10, "instr_halt", 16'h8008);

    // Random resets and observation selects against the model
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 24) == 0);
      t = 2'($urandom_range(0, 3));
      tick(r, t, $sformatf("rand%0d_t%0d", n, t), model_result(t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
